// File: rtl/data_memory_pkg.sv
// Shared constants and types for the MEM-stage data memory.
package data_memory_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 256;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/data_memory_addr_map.sv
// Maps a CPU byte address onto a word index of the local array,
// relative to the relocatable base address startin.
module data_memory_addr_map #(
  parameter int unsigned ADDR_W = data_memory_pkg::ADDR_W,
  parameter int unsigned DEPTH  = data_memory_pkg::DEFAULT_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] startin,
  output logic [IDX_W-1:0]  index,
  output logic              in_range
);

  logic [ADDR_W-1:0] offset;
  logic              unused_byte_sel;

  // Modular subtraction: addresses below the base wrap to a large offset
  // and therefore land out of range.
  always_comb begin
    offset          = address - startin;
    index           = offset[IDX_W+1:2];
    // (offset >> 2) < DEPTH with DEPTH a power of two is the same as all
    // bits above the word index being zero.
    in_range        = (offset[ADDR_W-1:IDX_W+2] == '0);
    // Byte-select bits are deliberately ignored: accesses are word aligned.
    unused_byte_sel = ^offset[1:0];
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory: synchronous write, combinational read,
// asynchronous active-low clear of the whole array.
module data_memory #(
  parameter int unsigned DATA_W = data_memory_pkg::DATA_W,
  parameter int unsigned ADDR_W = data_memory_pkg::ADDR_W,
  parameter int unsigned DEPTH  = data_memory_pkg::DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0] startin
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  index;
  logic              in_range;

  data_memory_addr_map #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_addr_map (
    .address  (address),
    .startin  (startin),
    .index    (index),
    .in_range (in_range)
  );

  // Storage: cleared asynchronously on reset; out-of-range writes dropped.
  // The index is derived from the startin value present at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write && in_range) begin
      mem[index] <= write_data;
    end
  end

  // Read mux: zero unless enabled, in range and out of reset.
  always_comb begin
    read_data = '0;
    if (rst_n && mem_read && in_range) begin
      read_data = mem[index];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard-driven bench for data_memory.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [31:0] startin;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  data_memory #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (256)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .startin    (startin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic push(input string n, input logic [31:0] a, input logic r,
                      input logic [31:0] d);
    exp_t x;
    x.name = n; x.addr = a; x.rd = r; x.data = d;
    sb.push_back(x);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; write_data = d; mem_write = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_write = 1'b0; mem_read = 1'b1;
    address = '0; write_data = '0; startin = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (read_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold: read_data=%h expected %h", read_data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push("reset_0x000", 32'h000, 1'b1, 32'h0);
    push("reset_0x3fc", 32'h3FC, 1'b1, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      address = e.addr; mem_read = e.rd; #1;
      n_cmp++;
      if (read_data !== e.data) begin
        n_err++;
        $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
      end
    end
  endtask

  task automatic test_basic();
    do_write(32'h04, 32'hDEADBEEF);
    push("basic_rd_04", 32'h04, 1'b1, 32'hDEADBEEF);
    do_write(32'h08, 32'hBEEFDEAD);
    push("basic_rd_08", 32'h08, 1'b1, 32'hBEEFDEAD);
    push("basic_reread_04", 32'h04, 1'b1, 32'hDEADBEEF);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      address = e.addr; mem_read = e.rd; #1;
      n_cmp++;
      if (read_data !== e.data) begin
        n_err++;
        $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
      end
    end
  endtask

  task automatic test_gating();
    push("gate_rd0_04", 32'h04, 1'b0, 32'h0);
    push("align_05", 32'h05, 1'b1, 32'hDEADBEEF);
    push("align_06", 32'h06, 1'b1, 32'hDEADBEEF);
    push("align_07", 32'h07, 1'b1, 32'hDEADBEEF);
    push("gate_rd0_08", 32'h08, 1'b0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      address = e.addr; mem_read = e.rd; #1;
      n_cmp++;
      if (read_data !== e.data) begin
        n_err++;
        $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
      end
    end
  endtask

  task automatic test_offset();
    @(negedge clk);
    startin = 32'h1000;
    do_write(32'h1000, 32'hCAFEF00D);
    do_write(32'h1010, 32'h12345678);
    // offset 0x400 -> index 256: must be dropped, not wrap onto index 0
    do_write(32'h1400, 32'hBADBAD00);
    push("base_rd_1010", 32'h1010, 1'b1, 32'h12345678);
    push("base_below_0ffc", 32'h0FFC, 1'b1, 32'h0);
    push("base_oob_1400", 32'h1400, 1'b1, 32'h0);
    push("base_prior_1000", 32'h1000, 1'b1, 32'hCAFEF00D);
    push("base_last_13fc", 32'h13FC, 1'b1, 32'h0);
    // index 1 at this base is the word written earlier at 0x04
    push("base_rd_1004", 32'h1004, 1'b1, 32'hDEADBEEF);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      address = e.addr; mem_read = e.rd; #1;
      n_cmp++;
      if (read_data !== e.data) begin
        n_err++;
        $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
      end
    end
    // combinational re-map when the base moves
    @(negedge clk);
    startin = 32'h0;
    push("remap_rd_10", 32'h10, 1'b1, 32'h12345678);
    push("remap_rd_00", 32'h00, 1'b1, 32'hCAFEF00D);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      address = e.addr; mem_read = e.rd; #1;
      n_cmp++;
      if (read_data !== e.data) begin
        n_err++;
        $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
      end
    end
  endtask

  task automatic test_hazard();
    do_write(32'h20, 32'h11111111);
    @(negedge clk);
    address = 32'h20; mem_read = 1'b1; mem_write = 1'b1;
    write_data = 32'h22222222;
    push("hazard_before", 32'h20, 1'b1, 32'h11111111);
    push("hazard_after", 32'h20, 1'b1, 32'h22222222);
    e = sb.pop_front();
    #1;
    n_cmp++;
    if (read_data !== e.data) begin
      n_err++;
      $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (read_data !== e.data) begin
      n_err++;
      $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
    end
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    address = 32'h04; mem_read = 1'b1; #1;
    n_cmp++;
    if (read_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL areset_pre: read_data=%h expected %h", read_data, 32'hDEADBEEF);
    end
    address = 32'h30; write_data = 32'hA5A5A5A5; mem_write = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    address = 32'h04;
    #1;
    n_cmp++;
    if (read_data !== 32'h0) begin
      n_err++;
      $display("FAIL areset_immediate: read_data=%h expected %h", read_data, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    rst_n = 1'b1;
    push("areset_04", 32'h04, 1'b1, 32'h0);
    push("areset_08", 32'h08, 1'b1, 32'h0);
    push("areset_10", 32'h10, 1'b1, 32'h0);
    push("areset_00", 32'h00, 1'b1, 32'h0);
    push("areset_20", 32'h20, 1'b1, 32'h0);
    push("areset_30", 32'h30, 1'b1, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      address = e.addr; mem_read = e.rd; #1;
      n_cmp++;
      if (read_data !== e.data) begin
        n_err++;
        $display("FAIL %s: read_data=%h expected %h", e.name, read_data, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gating();
    test_offset();
    test_hazard();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
